// File: rtl/reg_ctx_engine_if.sv
// Bus bundle for the context save/restore engine: control handshake plus
// register-file third-read/write ports and the data-memory port.
interface reg_ctx_engine_if #(
  parameter int NUM_DOMAINS = 1,
  parameter int MEM_ADDR_W  = 8
);
  localparam int DATA_W = NUM_DOMAINS * 8;

  logic                  start;
  logic                  dir;
  logic [MEM_ADDR_W-1:0] base_addr;
  logic [7:0]            reg_mask;
  logic                  busy;
  logic                  done;
  logic [2:0]            rf_rd_addr;
  logic [DATA_W-1:0]     rf_rd_data;
  logic [2:0]            rf_wr_addr;
  logic [DATA_W-1:0]     rf_wr_data;
  logic                  rf_wr_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wr_data;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [DATA_W-1:0]     mem_rd_data;

  // Environment side: core control, register file and data memory.
  modport master (
    output start, dir, base_addr, reg_mask, rf_rd_data, mem_rd_data,
    input  busy, done, rf_rd_addr, rf_wr_addr, rf_wr_data, rf_wr_en,
           mem_addr, mem_wr_data, mem_wr_en, mem_rd_en
  );

  // Engine side.
  modport slave (
    input  start, dir, base_addr, reg_mask, rf_rd_data, mem_rd_data,
    output busy, done, rf_rd_addr, rf_wr_addr, rf_wr_data, rf_wr_en,
           mem_addr, mem_wr_data, mem_wr_en, mem_rd_en
  );
endinterface

// File: rtl/reg_ctx_engine.sv
// Context save/restore sequencer: walks a masked subset of r0..r7, two cycles
// per selected register, copying regs->mem (save) or mem->regs (restore).
module reg_ctx_engine #(
  parameter int NUM_DOMAINS = 1,
  parameter int MEM_ADDR_W  = 8
) (
  input logic             clk,
  input logic             reset,
  reg_ctx_engine_if.slave bus
);
  localparam int DATA_W = NUM_DOMAINS * 8;

  typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            mask_q, mask_d;
  logic                  dir_q;
  logic [MEM_ADDR_W-1:0] base_q;
  logic [2:0]            sel_idx;
  logic [MEM_ADDR_W-1:0] slot;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (m[j]) idx = 3'(j);
    end
    return idx;
  endfunction

  assign sel_idx = lowest_set(mask_q);
  assign slot    = base_q + MEM_ADDR_W'(sel_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Transfer parameters only matter while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) begin
      dir_q  <= bus.dir;
      base_q <= bus.base_addr;
    end
  end

  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.rf_rd_addr  = 3'd0;
    bus.rf_wr_addr  = 3'd0;
    bus.rf_wr_data  = '0;
    bus.rf_wr_en    = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mask_d  = bus.reg_mask;
          state_d = (bus.reg_mask != 8'd0) ? PH_A : DONE;
        end
      end
      PH_A: begin
        bus.busy     = 1'b1;
        bus.mem_addr = slot;
        if (!dir_q) bus.rf_rd_addr = sel_idx;
        else        bus.mem_rd_en  = 1'b1;
        state_d = PH_B;
      end
      PH_B: begin
        bus.busy     = 1'b1;
        bus.mem_addr = slot;
        if (!dir_q) begin
          bus.rf_rd_addr  = sel_idx;
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_data = bus.rf_rd_data;
        end else begin
          bus.rf_wr_en   = 1'b1;
          bus.rf_wr_addr = sel_idx;
          bus.rf_wr_data = bus.mem_rd_data;
        end
        // Drop the lowest set bit: the register just finished.
        mask_d  = mask_q & (mask_q - 8'd1);
        state_d = (mask_d != 8'd0) ? PH_A : DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/reg_ctx_engine.md
# reg_ctx_engine

Register-file context save/restore sequencer for the 8-bit RISC/RNS core. On a start pulse it walks a masked subset of the eight architectural registers. It either copies them from the register file into data memory (save) or reloads them from data memory into the register file (restore). It drives the register file's third read port and its write port from the outside, one register per two cycles. It is the engine behind multi-register context switches that single RLOAD/RSTORE instructions cannot do efficiently.

## Interface
- NUM_DOMAINS, 1, number of RNS residue domains; data word width W = NUM_DOMAINS*8
- MEM_ADDR_W, 8, data-memory address width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; one clock domain only
- start  in  1  single-cycle request; sampled only in IDLE
- dir  in  1  0 = save (regs -> mem), 1 = restore (mem -> regs); latched with start
- base_addr  in  MEM_ADDR_W  memory slot base; latched with start
- reg_mask  in  8  bit i selects register i; latched with start
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle completion pulse
- rf_rd_addr  out  3  register-file read address (to the third read port)
- rf_rd_data  in  W  register-file read data, combinational from rf_rd_addr
- rf_wr_addr  out  3  register-file write address
- rf_wr_data  out  W  register-file write data
- rf_wr_en  out  1  register-file write enable, written at the next rising edge
- mem_addr  out  MEM_ADDR_W  data-memory address
- mem_wr_data  out  W  data-memory write data
- mem_wr_en  out  1  data-memory write enable
- mem_rd_en  out  1  data-memory read enable
- mem_rd_data  in  W  data-memory read data, valid the cycle after mem_rd_en (fixed latency 1)

## Operation
- States: IDLE, PH_A, PH_B, DONE.
- IDLE:
  - On start=1, latch dir/base_addr/reg_mask into a pending mask.
  - Mask nonzero -> PH_A; mask zero -> DONE.
- Register selection: the lowest set bit i of the pending mask, via a priority encoder. Unselected registers cost zero cycles.
- Memory slot is fixed per register: mem_addr = (base_addr + i) mod 2^MEM_ADDR_W. Wrap-around is silent.
- Save (dir=0):
  - PH_A: rf_rd_addr=i, mem_addr=slot.
  - PH_B: rf_rd_addr=i held, mem_wr_en=1, mem_wr_data=rf_rd_data.
- Restore (dir=1):
  - PH_A: mem_rd_en=1, mem_addr=slot.
  - PH_B: rf_wr_en=1, rf_wr_addr=i, rf_wr_data=mem_rd_data.
- End of PH_B: clear bit i. Remaining mask nonzero -> PH_A; zero -> DONE.
- DONE: done=1 for one cycle, then IDLE.
- Output gating:
  - Enables, addresses and busy are decoded from registered state, so they are glitch-free.
  - mem_wr_data and rf_wr_data are pass-through, forced to 0 outside their PH_B.
  - Idle-time addresses are 0.
- start while busy or in DONE is ignored; there is no queueing.
- Input changes after the start cycle have no effect, because all parameters are latched.
- Reset (async, active-low), at any time:
  - Return to IDLE and clear the pending mask.
  - busy, done, rf_wr_en, mem_wr_en, mem_rd_en, rf_rd_addr, rf_wr_addr, mem_addr, rf_wr_data, mem_wr_data all 0.
  - Partial transfers are not rolled back.
  - First start is accepted at the first rising edge after reset deasserts.

## Timing
- Let E0 be the rising edge that samples start in IDLE. Cycle k is the cycle after edge Ek-1.
- With N = popcount(reg_mask):
  - busy=1 in cycles 1..2N.
  - done=1 in cycle 2N+1.
  - IDLE from cycle 2N+2.
  - Next start sampled at the end of cycle 2N+2 at the earliest.
- N=0: busy never rises; done=1 in cycle 1; no enable ever asserted.
- Throughput: exactly 2 cycles per selected register, independent of mask sparsity.
- Save: memory write occurs at the edge ending PH_B.
- Restore:
  - Register write occurs at the edge ending PH_B.
  - mem_rd_data is consumed exactly one cycle after mem_rd_en.
- Enables are never asserted simultaneously: at most one of mem_wr_en, mem_rd_en, rf_wr_en is high per cycle.

## Test plan
- Reset: assert reset mid-cycle with no clock edge -> all outputs 0 immediately. Release, then start dir=0 mask=0x01 -> accepted on the first edge.
- Full save: regs r0..r7 = 0x10..0x17, base_addr=0x40, mask=0xFF, dir=0 -> mem_wr_en in cycles 2,4,...,16 at addresses 0x40..0x47 with data 0x10..0x17. busy cycles 1..16, done in cycle 17.
- Sparse restore with wrap: mem[0xFE]=0xAA, mem[0x05]=0x55, base_addr=0xFE, mask=0x81, dir=1:
  - mem_rd_en at 0xFE in cycle 1, then rf_wr_en r0=0xAA in cycle 2.
  - mem_rd_en at 0x05 in cycle 3, then rf_wr_en r7=0x55 in cycle 4.
  - done in cycle 5.
- Empty mask: start, mask=0x00 -> done=1 in cycle 1, busy and all enables stay 0.
- Collision and abort:
  - start pulses during busy and in DONE -> ignored, transfer count unchanged.
  - Reset asserted in cycle 3 of an 8-register save -> outputs 0 at once, only the first register written, engine in IDLE.
- NUM_DOMAINS=3: save then restore of mask=0x3C with 24-bit patterns 0xA5C3F0 etc. -> register contents bit-exact after the round trip.
